// File: rtl/input_word_assembler.sv
// Assembles NBYTES lane-indexed bytes into one word behind a valid/ready output stage.
// Enforces lane order, resynchronises on lane 0, and drops stalled partial words.
module input_word_assembler #(
  parameter int unsigned NBYTES  = 2,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IDX_W-1:0]      in_idx,
  input  logic [7:0]            in_byte,
  output logic [8*NBYTES-1:0]   out_word,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  seq_err,
  output logic                  timeout_err,
  output logic [7:0]            err_count
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [NBYTES-1:0][7:0] lanes_q, lanes_d;
  logic [IDX_W-1:0]       exp_q, exp_d;
  logic [CNT_W-1:0]       idle_q, idle_d;
  logic [8*NBYTES-1:0]    out_word_d;
  logic                   out_valid_d, seq_err_d, timeout_err_d, complete, accept;
  logic [7:0]             err_count_d;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    lanes_d       = lanes_q;
    exp_d         = exp_q;
    idle_d        = idle_q;
    out_word_d    = out_word;
    out_valid_d   = out_valid;
    seq_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    complete      = 1'b0;
    err_count_d   = err_count;

    if (out_valid && out_ready) out_valid_d = 1'b0;

    if (accept) begin
      idle_d = '0;
      if (in_idx == exp_q) begin
        for (int i = 0; i < NBYTES; i++) begin
          if (in_idx == IDX_W'(i)) lanes_d[i] = in_byte;
        end
        if (in_idx == IDX_W'(NBYTES - 1)) begin
          complete = 1'b1;
          exp_d    = '0;
        end else begin
          exp_d = exp_q + IDX_W'(1);
        end
      end else if (in_idx == '0) begin
        // Lane 0 mid-word restarts assembly with this byte.
        lanes_d[0] = in_byte;
        exp_d      = (NBYTES == 1) ? '0 : IDX_W'(1);
        complete   = (NBYTES == 1);
        seq_err_d  = 1'b1;
      end else begin
        exp_d     = '0;
        seq_err_d = 1'b1;
      end
    end else if (TIMEOUT > 0 && exp_q != '0) begin
      if (32'(idle_q) + 32'd1 >= TIMEOUT) begin
        exp_d         = '0;
        idle_d        = '0;
        timeout_err_d = 1'b1;
      end else begin
        idle_d = idle_q + CNT_W'(1);
      end
    end else begin
      idle_d = '0;
    end

    // A completion overrides the handshake clear, so back-to-back words never bubble.
    if (complete) begin
      out_word_d  = lanes_d;
      out_valid_d = 1'b1;
    end

    if ((seq_err_d || timeout_err_d) && err_count != 8'hff) err_count_d = err_count + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lanes_q     <= '0;
      exp_q       <= '0;
      idle_q      <= '0;
      out_word    <= '0;
      out_valid   <= 1'b0;
      seq_err     <= 1'b0;
      timeout_err <= 1'b0;
      err_count   <= '0;
    end else begin
      lanes_q     <= lanes_d;
      exp_q       <= exp_d;
      idle_q      <= idle_d;
      out_word    <= out_word_d;
      out_valid   <= out_valid_d;
      seq_err     <= seq_err_d;
      timeout_err <= timeout_err_d;
      err_count   <= err_count_d;
    end
  end

endmodule

// File: tb/tb_input_word_assembler.sv
// Bench for input_word_assembler: three configurations (2-byte with timeout, 4-byte, 1-byte)
// checked every cycle against a lane-collecting reference model plus literal spot checks.
module tb_input_word_assembler;

  localparam int NI = 3;
  localparam int SV = 0, SW = 1, SS = 2, ST = 3, SC = 4, SR = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int nb[NI]  = '{2, 4, 1};
  int tmo[NI] = '{4, 0, 0};
  int iw[NI]  = '{2, 3, 1};

  logic       iv[NI], ordy[NI];
  logic [2:0] ii[NI];
  logic [7:0] ib[NI];

  logic        irdy0, irdy1, irdy2, ov0, ov1, ov2, se0, se1, se2, te0, te1, te2;
  logic [7:0]  ec0, ec1, ec2, ow2;
  logic [15:0] ow0;
  logic [31:0] ow1;

  input_word_assembler #(.NBYTES(2), .IDX_W(2), .TIMEOUT(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy0), .in_idx(ii[0][1:0]),
    .in_byte(ib[0]), .out_word(ow0), .out_valid(ov0), .out_ready(ordy[0]),
    .seq_err(se0), .timeout_err(te0), .err_count(ec0));

  input_word_assembler #(.NBYTES(4), .IDX_W(3), .TIMEOUT(0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy1), .in_idx(ii[1]),
    .in_byte(ib[1]), .out_word(ow1), .out_valid(ov1), .out_ready(ordy[1]),
    .seq_err(se1), .timeout_err(te1), .err_count(ec1));

  input_word_assembler #(.NBYTES(1), .IDX_W(1), .TIMEOUT(0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy2), .in_idx(ii[2][0:0]),
    .in_byte(ib[2]), .out_word(ow2), .out_valid(ov2), .out_ready(ordy[2]),
    .seq_err(se2), .timeout_err(te2), .err_count(ec2));

  // Reference model: bytes collected so far for the word in progress, and the presented word.
  int          got[NI], idle[NI], mec[NI], quiet[NI];
  logic [7:0]  part[NI][4];
  bit          mv[NI], mse[NI], mte[NI];
  logic [31:0] mw[NI];
  int          n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[dut%0d] @%0t: got %0h, expected %0h", name, k, $time, act, exp);
    end
  endtask

  task automatic grab(input int k, output logic r, output logic v, output logic s,
                      output logic t, output logic [7:0] c, output logic [31:0] w);
    case (k)
      0: begin r = irdy0; v = ov0; s = se0; t = te0; c = ec0; w = 32'(ow0); end
      1: begin r = irdy1; v = ov1; s = se1; t = te1; c = ec1; w = ow1; end
      default: begin r = irdy2; v = ov2; s = se2; t = te2; c = ec2; w = 32'(ow2); end
    endcase
  endtask

  task automatic lit(input string name, input int k, input int sel, input logic [31:0] exp);
    logic r, v, s, t;
    logic [7:0] c;
    logic [31:0] w, a;
    grab(k, r, v, s, t, c, w);
    case (sel)
      SV: a = 32'(v);
      SW: a = w;
      SS: a = 32'(s);
      ST: a = 32'(t);
      SC: a = 32'(c);
      default: a = 32'(r);
    endcase
    chk(name, k, a, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      got[k] = 0; idle[k] = 0; mec[k] = 0; quiet[k] = 0;
      mv[k] = 0; mse[k] = 0; mte[k] = 0; mw[k] = '0;
    end
  endtask

  task automatic model_step(input int k);
    bit acc, nse, nte, nmv;
    acc = iv[k] && (!mv[k] || ordy[k]);
    nse = 0;
    nte = 0;
    nmv = mv[k] && !ordy[k];
    if (acc) begin
      idle[k] = 0;
      if (int'(ii[k]) == got[k]) begin
        part[k][got[k]] = ib[k];
        got[k]++;
        if (got[k] == nb[k]) begin
          mw[k] = '0;
          for (int i = 0; i < nb[k]; i++) mw[k] |= 32'(part[k][i]) << (8 * i);
          nmv = 1;
          got[k] = 0;
        end
      end else if (ii[k] == 3'd0) begin
        nse = 1;
        part[k][0] = ib[k];
        got[k] = 1;
      end else begin
        nse = 1;
        got[k] = 0;
      end
    end else if (tmo[k] > 0 && got[k] > 0) begin
      idle[k]++;
      if (idle[k] == tmo[k]) begin
        nte = 1;
        got[k] = 0;
        idle[k] = 0;
      end
    end else begin
      idle[k] = 0;
    end
    if (nse || nte) mec[k] = (mec[k] < 255) ? mec[k] + 1 : 255;
    mv[k] = nmv;
    mse[k] = nse;
    mte[k] = nte;
  endtask

  task automatic compare_all();
    logic r, v, s, t;
    logic [7:0] c;
    logic [31:0] w;
    for (int k = 0; k < NI; k++) begin
      grab(k, r, v, s, t, c, w);
      chk("out_valid", k, 32'(v), 32'(mv[k]));
      chk("out_word", k, w, mw[k]);
      chk("seq_err", k, 32'(s), 32'(mse[k]));
      chk("timeout_err", k, 32'(t), 32'(mte[k]));
      chk("err_count", k, 32'(c), 32'(mec[k]));
    end
  endtask

  task automatic tick();
    logic r, v, s, t;
    logic [7:0] c;
    logic [31:0] w;
    #1;
    for (int k = 0; k < NI; k++) begin
      grab(k, r, v, s, t, c, w);
      chk("in_ready", k, 32'(r), 32'(!mv[k] || ordy[k]));
      model_step(k);
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      iv[k] = 0; ordy[k] = 1; ii[k] = '0; ib[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    compare_all();
  endtask

  task automatic send(input int k, input int idx, input logic [7:0] b);
    iv[k] = 1;
    ii[k] = 3'(idx);
    ib[k] = b;
    tick();
    iv[k] = 0;
  endtask

  initial begin
    do_reset();
    lit("reset_in_ready", 0, SR, 1);

    // Basic 2-byte word, valid for one cycle.
    send(0, 0, 8'h34); send(0, 1, 8'h12);
    lit("t1_word", 0, SW, 32'h1234); lit("t1_valid", 0, SV, 1); lit("t1_seq", 0, SS, 0);
    tick();
    lit("t1_valid_drop", 0, SV, 0);

    // 4-byte word, then the same under backpressure.
    for (int i = 0; i < 4; i++) send(1, i, 8'(8'h11 * (i + 1)));
    lit("t2_word", 1, SW, 32'h44332211);
    tick();
    ordy[1] = 0;
    for (int i = 0; i < 4; i++) send(1, i, 8'(8'h11 * (i + 1)));
    iv[1] = 1; ii[1] = 3'd0; ib[1] = 8'h55;
    tick();
    lit("t2_stall_ready", 1, SR, 0);
    tick();
    lit("t2_stall_ready2", 1, SR, 0); lit("t2_held", 1, SW, 32'h44332211);
    lit("t2_held_valid", 1, SV, 1);
    ordy[1] = 1;
    tick();
    iv[1] = 0;
    lit("t2_released", 1, SV, 0);
    send(1, 1, 8'h66); send(1, 2, 8'h77); send(1, 3, 8'h88);
    lit("t2_word2", 1, SW, 32'h88776655);

    // Lane-0 restart mid-word.
    do_reset();
    send(0, 0, 8'hAA); send(0, 0, 8'hBB);
    lit("t3_seq", 0, SS, 1);
    send(0, 1, 8'hCC);
    lit("t3_word", 0, SW, 32'hCCBB); lit("t3_count", 0, SC, 1);

    // Out-of-order and illegal indices.
    do_reset();
    send(0, 1, 8'h55);
    lit("t4_seq1", 0, SS, 1);
    send(0, 3, 8'h66);
    lit("t4_seq2", 0, SS, 1); lit("t4_count", 0, SC, 2); lit("t4_novalid", 0, SV, 0);

    // Partial word times out on the fourth idle cycle.
    do_reset();
    send(0, 0, 8'h01);
    repeat (3) tick();
    lit("t5_no_to_yet", 0, ST, 0);
    tick();
    lit("t5_timeout", 0, ST, 1);
    send(0, 1, 8'h02);
    lit("t5_seq", 0, SS, 1); lit("t5_noword", 0, SV, 0); lit("t5_count", 0, SC, 2);

    // Single-byte words back to back: valid never drops.
    send(2, 0, 8'hA1);
    lit("t6_w1", 2, SW, 32'hA1);
    send(2, 0, 8'hB2);
    lit("t6_stay", 2, SV, 1); lit("t6_w2", 2, SW, 32'hB2);
    send(2, 1, 8'hC3);
    lit("t6_seq1", 2, SS, 1); lit("t6_drain", 2, SV, 0);

    // Asynchronous reset with a held word and a partial word in flight.
    ordy[1] = 0;
    for (int i = 0; i < 4; i++) send(1, i, 8'(i + 1));
    send(0, 0, 8'h77);
    rst = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      lit("rst_valid", k, SV, 0); lit("rst_word", k, SW, 0); lit("rst_count", k, SC, 0);
    end
    do_reset();

    // Randomised traffic with bursts, quiet spells and backpressure.
    for (int n = 0; n < 4000; n++) begin
      for (int k = 0; k < NI; k++) begin
        if (quiet[k] > 0) begin
          quiet[k]--;
          iv[k] = 0;
        end else begin
          if ($urandom_range(0, 39) == 0) quiet[k] = $urandom_range(2, 7);
          iv[k] = ($urandom_range(0, 3) != 0);
          ii[k] = ($urandom_range(0, 7) < 6) ? 3'(got[k])
                                              : 3'($urandom_range(0, (1 << iw[k]) - 1));
          ib[k] = 8'($urandom);
        end
        ordy[k] = ($urandom_range(0, 2) != 0);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
